// File: rtl/noc_flit_packer.sv
// rtl/noc_flit_packer.sv - packetiser turning a descriptor plus payload words into head/body/tail flits
//
// Ports:
//   clk, arst                  clock; synchronous active-low reset
//   pkt_valid_i / pkt_ready_o  descriptor handshake (pkt_x_i, pkt_y_i, pkt_len_i)
//   pld_valid_i / pld_ready_o  payload word handshake (pld_data_i)
//   write_o, data_o, full_i    ingress FIFO write port with full backpressure
//   busy_o                     packet in progress
//   pkt_cnt_o                  packets fully emitted, wrapping
module noc_flit_packer #(
  parameter int WIDTH = 34,
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             pkt_valid_i,
  output logic             pkt_ready_o,
  input  logic [X_W-1:0]   pkt_x_i,
  input  logic [Y_W-1:0]   pkt_y_i,
  input  logic [LEN_W-1:0] pkt_len_i,
  input  logic             pld_valid_i,
  output logic             pld_ready_o,
  input  logic [WIDTH-3:0] pld_data_i,
  output logic             write_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             full_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] pkt_cnt_o
);

  localparam int PW = WIDTH - 2;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t           state, state_nxt;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    head_pld;
  logic             len_zero;
  logic             last_body;
  logic             pkt_done;

  assign len_zero  = (len_q == '0);
  assign last_body = (rem_q == LEN_W'(1));

  // Head payload packed from the MSB down; unused low bits stay zero.
  always_comb begin
    head_pld = '0;
    head_pld[PW-1 -: X_W]                 = x_q;
    head_pld[PW-1-X_W -: Y_W]             = y_q;
    head_pld[PW-1-X_W-Y_W -: LEN_W]       = len_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!arst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pkt_valid_i) state_nxt = HEAD;
      HEAD: if (write_o)     state_nxt = len_zero ? IDLE : BODY;
      BODY: if (write_o && last_body) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Outputs; write_o is gated by full_i in every state so the FIFO never overflows.
  always_comb begin
    pkt_ready_o = 1'b0;
    pld_ready_o = 1'b0;
    write_o     = 1'b0;
    data_o      = '0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE: pkt_ready_o = 1'b1;
      HEAD: begin
        write_o = !full_i;
        data_o  = {(len_zero ? 2'b11 : 2'b00), head_pld};
      end
      BODY: begin
        pld_ready_o = !full_i;
        write_o     = pld_valid_i && !full_i;
        data_o      = {(last_body ? 2'b10 : 2'b01), pld_data_i};
      end
      default: ;
    endcase
  end

  assign pkt_done = write_o && (((state == HEAD) && len_zero) ||
                                ((state == BODY) && last_body));

  // Descriptor capture, remaining-word count and packet counter
  always_ff @(posedge clk) begin
    if (!arst) begin
      x_q   <= '0;
      y_q   <= '0;
      len_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state == IDLE && pkt_valid_i) begin
        x_q   <= pkt_x_i;
        y_q   <= pkt_y_i;
        len_q <= pkt_len_i;
        rem_q <= pkt_len_i;
      end
      if (state == BODY && write_o) rem_q <= rem_q - LEN_W'(1);
      if (pkt_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_noc_flit_packer.sv
// tb/tb_noc_flit_packer.sv - directed vector bench for noc_flit_packer
module tb_noc_flit_packer;

  logic        clk;
  logic        arst;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [1:0]  pkt_x_i;
  logic [1:0]  pkt_y_i;
  logic [7:0]  pkt_len_i;
  logic        pld_valid_i;
  logic        pld_ready_o;
  logic [31:0] pld_data_i;
  logic        write_o;
  logic [33:0] data_o;
  logic        full_i;
  logic        busy_o;
  logic [1:0]  pkt_cnt_o;

  int total = 0;
  int bad   = 0;

  noc_flit_packer #(.WIDTH(34), .X_W(2), .Y_W(2), .LEN_W(8), .CNT_W(2)) dut (
    .clk(clk), .arst(arst),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_x_i(pkt_x_i), .pkt_y_i(pkt_y_i), .pkt_len_i(pkt_len_i),
    .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o), .pld_data_i(pld_data_i),
    .write_o(write_o), .data_o(data_o), .full_i(full_i),
    .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [1:0]  x, y;
    logic [7:0]  len;
    logic        dv;
    logic [31:0] d;
    logic        full;
    logic        ew;
    logic        cd;
    logic [33:0] ed;
    logic        epr, edr, eb;
    logic [1:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] A  = 32'hA1A1_A1A1, B  = 32'hB2B2_B2B2, C  = 32'hC3C3_C3C3;
  localparam logic [31:0] P  = 32'h1234_5678, Q  = 32'h9ABC_DEF0;
  localparam logic [31:0] W0 = 32'h0000_0010, W1 = 32'h0000_0011;
  localparam logic [31:0] W2 = 32'h0000_0012, W3 = 32'h0000_0013;
  localparam logic [33:0] H1 = 34'h0_6030_0000;  // x=1 y=2 len=3
  localparam logic [33:0] H2 = 34'h3_F000_0000;  // x=3 y=3 len=0, head+tail
  localparam logic [33:0] H3 = 34'h0_9020_0000;  // x=2 y=1 len=2
  localparam logic [33:0] H4 = 34'h0_0040_0000;  // x=0 y=0 len=4
  localparam logic [33:0] H5 = 34'h0_5010_0000;  // x=1 y=1 len=1
  localparam logic [33:0] H6 = 34'h0_4010_0000;  // x=1 y=0 len=1

  function automatic logic [33:0] fl(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  task automatic add(input logic pv, input logic [1:0] x, y, input logic [7:0] len,
                     input logic dv, input logic [31:0] d, input logic full,
                     input logic ew, input logic cd, input logic [33:0] ed,
                     input logic epr, input logic edr, input logic eb, input logic [1:0] ecnt);
    vec_t v;
    v.pv = pv; v.x = x; v.y = y; v.len = len; v.dv = dv; v.d = d; v.full = full;
    v.ew = ew; v.cd = cd; v.ed = ed; v.epr = epr; v.edr = edr; v.eb = eb; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rn, input logic pv, input logic [1:0] x, y,
                       input logic [7:0] len, input logic dv, input logic [31:0] d,
                       input logic full);
    @(negedge clk);
    arst = rn; pkt_valid_i = pv; pkt_x_i = x; pkt_y_i = y; pkt_len_i = len;
    pld_valid_i = dv; pld_data_i = d; full_i = full;
    #1;
  endtask

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ctrl = {write, pld_ready, pkt_ready, busy, cnt[1:0]}
  function automatic logic [33:0] ctrl(input logic w, dr, pr, b, input logic [1:0] c);
    return 34'({w, dr, pr, b, c});
  endfunction

  initial begin
    arst = 1'b0; pkt_valid_i = 1'b0; pkt_x_i = '0; pkt_y_i = '0; pkt_len_i = '0;
    pld_valid_i = 1'b0; pld_data_i = '0; full_i = 1'b0;

    // single packet x=1 y=2 len=3
    add(1,1,2,3, 0,0,0,  0,1,0,            1,0,0,0);
    add(0,0,0,0, 0,0,0,  1,1,H1,           0,0,1,0);
    add(0,0,0,0, 1,A,0,  1,1,fl(2'b01,A),  0,1,1,0);
    add(0,0,0,0, 1,B,0,  1,1,fl(2'b01,B),  0,1,1,0);
    add(0,0,0,0, 1,C,0,  1,1,fl(2'b10,C),  0,1,1,0);
    add(0,0,0,0, 0,0,0,  0,1,0,            1,0,0,1);
    // len=0 packet, payload offered but never consumed
    add(1,3,3,0, 1,A,0,  0,1,0,            1,0,0,1);
    add(0,0,0,0, 1,A,0,  1,1,H2,           0,0,1,1);
    add(0,0,0,0, 1,A,0,  0,1,0,            1,0,0,2);
    // backpressure in HEAD and mid-BODY
    add(1,2,1,2, 1,P,0,  0,1,0,            1,0,0,2);
    for (int i = 0; i < 5; i++)
      add(0,0,0,0, 1,P,1, 0,1,H3,          0,0,1,2);
    add(0,0,0,0, 1,P,0,  1,1,H3,           0,0,1,2);
    add(0,0,0,0, 1,P,0,  1,1,fl(2'b01,P),  0,1,1,2);
    for (int i = 0; i < 5; i++)
      add(0,0,0,0, 1,Q,1, 0,1,fl(2'b10,Q), 0,0,1,2);
    add(0,0,0,0, 1,Q,0,  1,1,fl(2'b10,Q),  0,1,1,2);
    add(0,0,0,0, 0,0,0,  0,1,0,            1,0,0,3);
    // len=4 with pld_valid toggling; counter wraps 3 -> 0 at the end
    add(1,0,0,4, 0,0,0,  0,1,0,            1,0,0,3);
    add(0,0,0,0, 0,0,0,  1,1,H4,           0,0,1,3);
    add(0,0,0,0, 1,W0,0, 1,1,fl(2'b01,W0), 0,1,1,3);
    add(0,0,0,0, 0,0,0,  0,0,0,            0,1,1,3);
    add(0,0,0,0, 1,W1,0, 1,1,fl(2'b01,W1), 0,1,1,3);
    add(0,0,0,0, 0,0,0,  0,0,0,            0,1,1,3);
    add(0,0,0,0, 1,W2,0, 1,1,fl(2'b01,W2), 0,1,1,3);
    add(0,0,0,0, 0,0,0,  0,0,0,            0,1,1,3);
    add(0,0,0,0, 1,W3,0, 1,1,fl(2'b10,W3), 0,1,1,3);
    add(0,0,0,0, 0,0,0,  0,1,0,            1,0,0,0);

    // reset state
    drive(0, 0,0,0,0, 0,0,0);
    drive(0, 1,1,1,1, 1,A,0);
    chk("reset_ctrl", ctrl(write_o, pld_ready_o, 1'b0, busy_o, pkt_cnt_o), ctrl(0,0,0,0,2'd0));
    chk("reset_data", data_o, 34'h0);

    foreach (vecs[i]) begin
      drive(1, vecs[i].pv, vecs[i].x, vecs[i].y, vecs[i].len,
            vecs[i].dv, vecs[i].d, vecs[i].full);
      chk($sformatf("vec%0d_ctrl", i), ctrl(write_o, pld_ready_o, pkt_ready_o, busy_o, pkt_cnt_o),
          ctrl(vecs[i].ew, vecs[i].edr, vecs[i].epr, vecs[i].eb, vecs[i].ecnt));
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), data_o, vecs[i].ed);
    end

    // back-to-back len=1 descriptors held valid: head, tail, gap; 4th wraps counter
    for (int k = 0; k < 12; k++) begin
      logic [31:0] d;
      d = 32'h5000_0000 + 32'(k);
      drive(1, 1,1,1,1, 1,d,0);
      chk($sformatf("b2b%0d_write", k), 34'(write_o), 34'(k % 3 != 0));
      if (k % 3 == 1) chk($sformatf("b2b%0d_head", k), data_o, H5);
      if (k % 3 == 2) chk($sformatf("b2b%0d_tail", k), data_o, fl(2'b10, d));
      if (k == 9) chk("b2b_cnt3", 34'(pkt_cnt_o), 34'd3);
    end
    drive(1, 0,0,0,0, 0,0,0);
    chk("b2b_wrap", ctrl(write_o, pld_ready_o, pkt_ready_o, busy_o, pkt_cnt_o), ctrl(0,0,1,0,2'd0));

    // one len=0 packet so the counter is nonzero before the reset test
    drive(1, 1,3,3,0, 0,0,0);
    drive(1, 0,0,0,0, 0,0,0);
    drive(1, 0,0,0,0, 0,0,0);
    chk("pre_rst_cnt", 34'(pkt_cnt_o), 34'd1);

    // reset after 2nd body flit of a len=5 packet
    drive(1, 1,2,2,5, 0,0,0);
    drive(1, 0,0,0,0, 0,0,0);
    chk("rst_pkt_head", 34'(write_o), 34'd1);
    drive(1, 0,0,0,0, 1,A,0);
    drive(1, 0,0,0,0, 1,B,0);
    chk("rst_pkt_body2", data_o, fl(2'b01, B));
    drive(0, 0,0,0,0, 1,C,0);
    drive(1, 1,1,0,1, 1,C,0);
    chk("after_rst", ctrl(write_o, pld_ready_o, pkt_ready_o, busy_o, pkt_cnt_o), ctrl(0,0,1,0,2'd0));
    drive(1, 0,0,0,0, 1,C,0);
    chk("new_head", data_o, H6);
    chk("new_head_w", 34'(write_o), 34'd1);
    drive(1, 0,0,0,0, 1,C,0);
    chk("new_tail", data_o, fl(2'b10, C));
    chk("new_tail_w", 34'(write_o), 34'd1);
    drive(1, 0,0,0,0, 0,0,0);
    chk("new_done", ctrl(write_o, pld_ready_o, pkt_ready_o, busy_o, pkt_cnt_o), ctrl(0,0,1,0,2'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_flit_packer.md
Name: noc_flit_packer

Overview:
- Packetiser directly upstream of the NoC ingress FIFO (SLOTS/WIDTH FIFO with write/full interface).
- Accepts a packet descriptor (destination X/Y plus payload length), then a stream of payload words.
- Emits a head flit, then body flits, then a tail flit, each WIDTH bits wide.
- Drives the FIFO write port and honours the FIFO's full flag as backpressure.

Parameters:
- WIDTH, 34: flit width. Bits [WIDTH-1:WIDTH-2] are the flit type; bits [WIDTH-3:0] are the payload.
- X_W, 2: destination X field width.
- Y_W, 2: destination Y field width.
- LEN_W, 8: payload-length field width. Constraint: X_W+Y_W+LEN_W <= WIDTH-2.
- CNT_W, 16: width of the completed-packet counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- arst  input  1  reset: synchronous, active-low (asserted when 0, sampled on the clk rising edge).
- pkt_valid_i  input  1  descriptor valid.
- pkt_ready_o  output  1  descriptor accepted when valid&ready.
- pkt_x_i  input  X_W  destination X.
- pkt_y_i  input  Y_W  destination Y.
- pkt_len_i  input  LEN_W  number of payload words (0 allowed).
- pld_valid_i  input  1  payload word valid.
- pld_ready_o  output  1  payload word consumed when valid&ready.
- pld_data_i  input  WIDTH-2  payload word.
- write_o  output  1  FIFO write strobe.
- data_o  output  WIDTH  flit to FIFO.
- full_i  input  1  FIFO full.
- busy_o  output  1  high in any state other than IDLE.
- pkt_cnt_o  output  CNT_W  packets fully emitted, modulo 2^CNT_W.

Behaviour:
- Flit types (data_o[WIDTH-1:WIDTH-2]):
  - 2'b00 head
  - 2'b01 body
  - 2'b10 tail
  - 2'b11 head+tail (used only when len=0)
- Head payload layout, packed from the MSB: [WIDTH-3 -: X_W]=x, then Y_W=y, then LEN_W=len, remaining low bits=0.
  - With defaults: [31:30]=x, [29:28]=y, [27:20]=len, [19:0]=0.
- Body/tail payload = pld_data_i, passed through combinationally.
- FSM states: IDLE, HEAD, BODY.
- IDLE:
  - pkt_ready_o=1, write_o=0, pld_ready_o=0.
  - On pkt_valid_i: register x, y, len; set rem=len; go to HEAD next cycle.
- HEAD:
  - pkt_ready_o=0, pld_ready_o=0.
  - data_o = head flit; write_o = !full_i.
  - On write with len=0: type is 2'b11; increment pkt_cnt_o; go to IDLE.
  - On write with len>0: go to BODY.
  - If full_i=1: hold HEAD; data_o stays stable.
- BODY:
  - pld_ready_o = !full_i; write_o = pld_valid_i & !full_i.
  - Flit type = tail if rem==1, else body.
  - Each write decrements rem.
  - Write with rem==1: increment pkt_cnt_o and go to IDLE.
  - pld_valid_i=0 or full_i=1: no write, no state change.
- write_o never asserts while full_i=1 (the FIFO must not see overflow writes). write_o is combinational from state, full_i and pld_valid_i.
- Latency:
  - Head flit is presentable the cycle after descriptor acceptance.
  - Body flits stream at 1 per cycle with no bubbles when pld_valid_i=1 and full_i=0.
  - One mandatory IDLE cycle between packets (pkt_ready_o only in IDLE).
- pld_valid_i in IDLE/HEAD is ignored (pld_ready_o=0; the word is not consumed).
- Descriptor inputs are don't-care outside IDLE.
- pkt_cnt_o wraps from 2^CNT_W-1 to 0.
- Reset values: state=IDLE, rem=0, pkt_cnt_o=0, busy_o=0, write_o=0, pld_ready_o=0, pkt_ready_o=1 once released. Registered x/y/len are cleared to 0; data_o is therefore 0 in IDLE.
- Reset asserted mid-packet:
  - The next rising edge forces IDLE; the partial packet is abandoned and no tail is emitted.
  - pkt_cnt_o is cleared.
  - write_o is 0 in the cycle after the reset edge.
- busy_o = (state != IDLE).

Test Plan:
- Single packet, x=1, y=2, len=3, payload A,B,C; full_i=0 → 4 writes:
  - 0x0_6030_0000 (type 00, [31:30]=01, [29:28]=10, [27:20]=03)
  - {01,A}, {01,B}, {10,C}
  - pkt_cnt_o=1, busy_o low after the last write.
- len=0, x=3, y=3 → exactly one write: data_o=0x3_F000_0000 (type 11); pld_ready_o never asserts; pkt_cnt_o increments.
- full_i held 1 for 5 cycles during HEAD and again mid-BODY:
  - write_o=0 and pld_ready_o=0 throughout.
  - data_o is stable and no payload word is consumed.
  - The flit sequence after release is identical to the no-backpressure case.
- pld_valid_i toggled 1/0 during a len=4 packet → writes only on valid cycles; 4th payload word tagged tail; no extra or missing flits.
- arst=0 for one cycle after the 2nd body flit of a len=5 packet:
  - busy_o=0, pkt_cnt_o=0 next cycle.
  - A new packet (len=1) then produces a head flit and a tail flit.
- Back-to-back descriptors held valid for 3 len=1 packets:
  - Writes follow the pattern head, tail, gap, repeated.
  - pkt_cnt_o=3.
  - With CNT_W=2, a 4th packet wraps pkt_cnt_o to 0.
